// File: rtl/serial_frame_rx_pkg.sv
// Shared definitions for the serial frame receiver: FSM encoding, line levels
// and a helper for sizing the bit counter.
package serial_frame_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

  // Width of an index able to address WIDTH bits (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_shift_in.sv
// Indexed shift-in register: writes one serial bit at a chosen position,
// clears on request, and exposes the running XOR of its contents.
module serial_shift_in #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] idx,
  input  logic             din,
  output logic [WIDTH-1:0] q,
  output logic             par
);

  // Bit-addressed capture; clear has priority over a write.
  // NOTE: this register is cleared by reset because its value is visible
  // through the parity output and reset must leave a known word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (wr_en) begin
      q[idx] <= din;
    end
  end

  assign par = ^q;

endmodule

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start bit, LSB-first data, optional parity, stop
// bit. Delivers words over a valid/ack handshake and pulses error flags.
module serial_frame_rx
  import serial_frame_rx_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             rd_ack,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             parity_err,
  output logic             framing_err,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned      CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic             ODD      = 1'(PARITY_ODD);

  rx_state_e        state, state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic             par_bad;
  logic [WIDTH-1:0] shreg;
  logic             shreg_par;
  logic             start_det;
  logic             good_frame;

  assign start_det  = (state == ST_IDLE) && (sin == START_BIT);
  assign good_frame = (state == ST_STOP) && (sin == STOP_BIT) && !par_bad;

  serial_shift_in #(
    .WIDTH (WIDTH),
    .IDX_W (CNT_W)
  ) u_shift (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_det),
    .wr_en (state == ST_DATA),
    .idx   (bit_cnt),
    .din   (sin),
    .q     (shreg),
    .par   (shreg_par)
  );

  // State register.
  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples the pre-edge values of its sources.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode; one line sample per cycle.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (sin != IDLE_LEVEL) state_nxt = ST_DATA;
      ST_DATA:   if (bit_cnt == LAST_IDX)
                   state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: state_nxt = ST_STOP;
      ST_STOP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Bit counter and latched parity verdict for the frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      par_bad <= 1'b0;
    end else begin
      if (start_det) begin
        bit_cnt <= '0;
        par_bad <= 1'b0;
      end else if (state == ST_DATA && bit_cnt != LAST_IDX) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == ST_PARITY) par_bad <= ((shreg_par ^ sin) != ODD);
    end
  end

  // Delivered word, handshake and one-cycle error pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
      if (good_frame) begin
        data_out   <= shreg;
        data_valid <= 1'b1;
        overrun    <= data_valid && !rd_ack;
      end else if (data_valid && rd_ack) begin
        data_valid <= 1'b0;
      end
      if (state == ST_STOP) begin
        framing_err <= (sin != STOP_BIT);
        parity_err  <= (sin == STOP_BIT) && par_bad;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx (WIDTH=4, even parity): directed
// frames from the test plan followed by randomized frames against a model.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sin = 1'b0;
  logic       rd_ack = 1'b0;
  logic [3:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       framing_err;
  logic       overrun;
  logic       busy;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference model state: the word a consumer should currently see.
  logic [3:0] exp_data  = 4'h0;
  logic       exp_valid = 1'b0;

  serial_frame_rx #(
    .WIDTH      (4),
    .PARITY_EN  (1),
    .PARITY_ODD (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sin         (sin),
    .rd_ack      (rd_ack),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .parity_err  (parity_err),
    .framing_err (framing_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic pe, input logic fe,
                           input logic ov, input logic bsy);
    check({tag, "_data"},  16'(data_out),    16'(exp_data));
    check({tag, "_valid"}, 16'(data_valid),  16'(exp_valid));
    check({tag, "_perr"},  16'(parity_err),  16'(pe));
    check({tag, "_ferr"},  16'(framing_err), 16'(fe));
    check({tag, "_ovr"},   16'(overrun),     16'(ov));
    check({tag, "_busy"},  16'(busy),        16'(bsy));
  endtask

  // Drives one complete frame; rd_ack is applied only on the stop-bit cycle.
  task automatic send_frame(input logic [3:0] w, input logic pbit,
                            input logic sbit, input logic ack_stop, input string tag);
    logic ok, good, pe, fe, ov;
    sin = 1'b1;
    rd_ack = 1'b0;
    step();
    check_all({tag, "_start"}, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      sin = w[i];
      step();
    end
    sin = pbit;
    step();
    sin = sbit;
    rd_ack = ack_stop;
    ok   = ((($countones(w) + int'(pbit)) % 2) == 0);
    good = !sbit && ok;
    fe   = sbit;
    pe   = !sbit && !ok;
    ov   = good && exp_valid && !ack_stop;
    if (good) begin
      exp_data  = w;
      exp_valid = 1'b1;
    end else if (ack_stop) begin
      exp_valid = 1'b0;
    end
    step();
    check_all({tag, "_stop"}, pe, fe, ov, 1'b0);
    sin = 1'b0;
    rd_ack = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    sin = 1'b0;
    rd_ack = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      check_all(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic ack_cycle(input string tag);
    sin = 1'b0;
    rd_ack = 1'b1;
    step();
    exp_valid = 1'b0;
    rd_ack = 1'b0;
    check_all(tag, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] w;
    logic       pbit, sbit, ack;
    int         gap;

    // Reset state.
    rst = 1'b0;
    step();
    step();
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // Idle noise: a line held low never starts a frame.
    idle(20, "idle_noise");

    // Good frame 4'hB, then acknowledge.
    send_frame(4'hB, 1'b1, 1'b0, 1'b0, "good_b");
    ack_cycle("ack_b");

    // Parity error: word kept, pulse lasts one cycle.
    send_frame(4'hB, 1'b0, 1'b0, 1'b0, "par_err");
    idle(1, "par_err_after");

    // Framing error has priority over the bad parity in this frame.
    send_frame(4'h2, 1'b0, 1'b1, 1'b0, "frm_err");
    idle(1, "frm_err_after");
    send_frame(4'h5, 1'b0, 1'b0, 1'b0, "good_5");
    ack_cycle("ack_5");

    // Back-to-back good frames without ack: overrun.
    send_frame(4'hB, 1'b1, 1'b0, 1'b0, "ovr_a");
    send_frame(4'h5, 1'b0, 1'b0, 1'b0, "ovr_b");
    idle(1, "ovr_after");
    ack_cycle("ack_ovr");

    // Same-cycle ack on the second stop bit: no overrun, valid stays high.
    send_frame(4'hB, 1'b1, 1'b0, 1'b0, "sameack_a");
    send_frame(4'h5, 1'b0, 1'b0, 1'b1, "sameack_b");
    ack_cycle("ack_same");

    // Reset mid-frame aborts with no flags.
    sin = 1'b1;
    step();
    step();
    step();
    rst = 1'b0;
    sin = 1'b0;
    exp_data  = 4'h0;
    exp_valid = 1'b0;
    #1;
    check_all("rst_mid_async", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    check_all("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(4'hA, 1'b0, 1'b0, 1'b0, "good_a");
    ack_cycle("ack_a");

    // Randomized frames with random gaps (including back-to-back) and acks.
    for (int n = 0; n < 40; n++) begin
      w    = 4'($urandom_range(0, 15));
      pbit = 1'(($countones(w)) % 2);
      if ($urandom_range(0, 3) == 0) pbit = ~pbit;
      sbit = ($urandom_range(0, 5) == 0);
      ack  = 1'($urandom_range(0, 1));
      send_frame(w, pbit, sbit, ack, "rand");
      gap = int'($urandom_range(0, 2));
      if (gap > 0) idle(gap, "rand_gap");
      if ($urandom_range(0, 2) == 0) ack_cycle("rand_ack");
    end

    idle(2, "final");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
